// File: rtl/queen_job_scheduler_pkg.sv
// Shared types and constants for the 8-queen job scheduler.
// The QUEEN_TIMEOUT_EN build uses the ABORT encoding below.
package queen_job_scheduler_pkg;

    localparam int QJ_BOARD = 8;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_START     = 4'd1;
    localparam logic [3:0] ST_WAIT_DONE = 4'd2;
    localparam logic [3:0] ST_CAPTURE   = 4'd3;
    localparam logic [3:0] ST_DRAIN     = 4'd4;
    localparam logic [3:0] ST_ABORT     = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_START     = ST_START,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_CAPTURE   = ST_CAPTURE,
        S_DRAIN     = ST_DRAIN,
        S_ABORT     = ST_ABORT
    } qj_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int qj_width(input int n);
        qj_width = (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/queen_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module queen_job_scheduler_rr_arbiter
    import queen_job_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = qj_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Scan requesters starting at the pointer and keep the first hit.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/queen_job_scheduler.sv
// Shares one 8-queen solver among NUM_REQ requesters and streams each result back.
// Optional watchdog/abort path enabled with `define QUEEN_TIMEOUT_EN.
module queen_job_scheduler
    import queen_job_scheduler_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int BOARD          = QJ_BOARD,
    parameter  int TIMEOUT_CYCLES = 65535,
    localparam int ID_W           = qj_width(NUM_REQ),
    localparam int ROW_W          = qj_width(BOARD)
) (
    input  logic               clk,
    input  logic               user_reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    input  logic               solver_ready,
    output logic               solver_start,
    output logic               solver_reset,
    input  logic               solver_done,
    input  logic               solver_out_valid,
    input  logic [BOARD-1:0]   solver_out_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BOARD-1:0]   rsp_data,
    output logic [ROW_W-1:0]   rsp_row,
    output logic               rsp_last,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_err,
    output logic               busy
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BOARD - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    qj_state_e          state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] arb_grant_s;
    logic [ID_W-1:0]    arb_id_s;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    next_ptr_s;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [BOARD-1:0]   buf_q [BOARD];
    logic [BOARD-1:0]   buf_d [BOARD];
    logic               start_q, start_d;
`ifdef QUEEN_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0]        tmo_q, tmo_d;
    logic               abort_rst_q, abort_rst_d;
`endif

    queen_job_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant_s)
    );

    // One-hot arbiter result to requester index; pointer advances past the winner.
    always_comb begin
        arb_id_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant_s[i]) begin
                arb_id_s = ID_W'(i);
            end else begin
                arb_id_s = arb_id_s;
            end
        end
        next_ptr_s = (id_q == ID_LAST) ? '0 : id_q + 1'b1;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        row_d   = row_q;
        buf_d   = buf_q;
        start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = arb_grant_s;
                    id_d    = arb_id_s;
                    state_d = S_START;
                end else begin
                    grant_d = '0;
                end
            end
            S_START: begin
                if (solver_ready) begin
                    start_d = 1'b1;
                    state_d = S_WAIT_DONE;
                end else begin
                    start_d = 1'b0;
                end
            end
            S_WAIT_DONE: begin
                // A row word coincident with done is deliberately not captured.
                if (solver_done) begin
                    row_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_CAPTURE: begin
                if (solver_out_valid) begin
                    buf_d[row_q] = solver_out_data;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    row_d = row_q;
                end
            end
            S_DRAIN: begin
                if (rsp_ready) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        grant_d = '0;
                        ptr_d   = next_ptr_s;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    row_d = row_q;
                end
            end
`ifdef QUEEN_TIMEOUT_EN
            S_ABORT: begin
                // First ABORT cycle resets the solver; the error beat follows.
                if (!abort_rst_q && rsp_ready) begin
                    grant_d = '0;
                    ptr_d   = next_ptr_s;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ABORT;
                end
            end
`endif
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

`ifdef QUEEN_TIMEOUT_EN
        tmo_d = tmo_q;
        if (state_d == S_START && state_q != S_START) begin
            tmo_d = 16'd0;
        end else if (state_q == S_WAIT_DONE || state_q == S_CAPTURE) begin
            if (tmo_q == TMO_LIMIT - 16'd1) begin
                row_d   = '0;
                state_d = S_ABORT;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end else begin
            tmo_d = tmo_q;
        end
        abort_rst_d = (state_d == S_ABORT) && (state_q != S_ABORT);
`endif
    end

    // State, control and result-buffer registers.
    always_ff @(posedge clk) begin
        if (!user_reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            row_q   <= '0;
            start_q <= 1'b0;
            for (int r = 0; r < BOARD; r++) begin
                buf_q[r] <= '0;
            end
`ifdef QUEEN_TIMEOUT_EN
            tmo_q       <= 16'd0;
            abort_rst_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            row_q   <= row_d;
            start_q <= start_d;
            buf_q   <= buf_d;
`ifdef QUEEN_TIMEOUT_EN
            tmo_q       <= tmo_d;
            abort_rst_q <= abort_rst_d;
`endif
        end
    end

    assign grant        = grant_q;
    assign rsp_id       = id_q;
    assign solver_start = start_q;
    assign busy         = (state_q != S_IDLE);

    // Response stream decode from the registered state and row pointer.
    always_comb begin
        rsp_valid = (state_q == S_DRAIN);
        rsp_row   = row_q;
        rsp_data  = rsp_valid ? buf_q[row_q] : '0;
        rsp_last  = rsp_valid && (row_q == ROW_LAST);
        rsp_err   = 1'b0;
`ifdef QUEEN_TIMEOUT_EN
        solver_reset = !user_reset_n || abort_rst_q;
        if (state_q == S_ABORT && !abort_rst_q) begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
            rsp_last  = 1'b1;
            rsp_row   = '0;
            rsp_data  = '0;
        end else begin
            rsp_err = 1'b0;
        end
`else
        solver_reset = !user_reset_n;
`endif
    end

endmodule

// File: tb/tb_queen_job_scheduler.sv
// Directed self-checking bench for queen_job_scheduler (default build, NUM_REQ=4, BOARD=8).
module tb_queen_job_scheduler;

    logic       clk = 1'b0;
    logic       user_reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic       solver_ready;
    logic       solver_start;
    logic       solver_reset;
    logic       solver_done;
    logic       solver_out_valid;
    logic [7:0] solver_out_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_row;
    logic       rsp_last;
    logic [1:0] rsp_id;
    logic       rsp_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] words_a   [8] = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
    logic [7:0] words_b   [8] = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h01, 8'h04, 8'h40, 8'h10};
    logic [7:0] cur_words [8];

    queen_job_scheduler #(
        .NUM_REQ        (4),
        .BOARD          (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk              (clk),
        .user_reset_n     (user_reset_n),
        .req              (req),
        .grant            (grant),
        .solver_ready     (solver_ready),
        .solver_start     (solver_start),
        .solver_reset     (solver_reset),
        .solver_done      (solver_done),
        .solver_out_valid (solver_out_valid),
        .solver_out_data  (solver_out_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_row          (rsp_row),
        .rsp_last         (rsp_last),
        .rsp_id           (rsp_id),
        .rsp_err          (rsp_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // From IDLE with req set: arbitrate, start pulse, done (with a word that must be ignored).
    task automatic job_to_capture(input int id);
        tick();
        chk("grant_after_arb", 32'(grant), 32'(1 << id));
        chk("busy_in_start", 32'(busy), 32'd1);
        chk("start_not_yet", 32'(solver_start), 32'd0);
        tick();
        chk("start_pulse", 32'(solver_start), 32'd1);
        chk("grant_held", 32'(grant), 32'(1 << id));
        solver_done      = 1'b1;
        solver_out_valid = 1'b1;
        solver_out_data  = 8'hFF;
        tick();
        solver_done      = 1'b0;
        solver_out_valid = 1'b0;
        chk("start_single", 32'(solver_start), 32'd0);
    endtask

    task automatic capture_rows(input int n);
        for (int i = 0; i < n; i++) begin
            solver_out_valid = 1'b1;
            solver_out_data  = cur_words[i];
            tick();
        end
        solver_out_valid = 1'b0;
        solver_out_data  = 8'h00;
    endtask

    task automatic drain_all(input int id);
        rsp_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            chk("drain_valid", 32'(rsp_valid), 32'd1);
            chk("drain_row", 32'(rsp_row), 32'(r));
            chk("drain_data", 32'(rsp_data), 32'(cur_words[r]));
            chk("drain_last", 32'(rsp_last), 32'(r == 7));
            chk("drain_id", 32'(rsp_id), 32'(id));
            chk("drain_grant", 32'(grant), 32'(1 << id));
            chk("drain_err", 32'(rsp_err), 32'd0);
            tick();
        end
        rsp_ready = 1'b0;
        chk("post_drain_valid", 32'(rsp_valid), 32'd0);
        chk("post_drain_grant", 32'(grant), 32'd0);
    endtask

    task automatic full_job(input int id);
        job_to_capture(id);
        capture_rows(8);
        chk("capture_to_rsp", 32'(rsp_valid), 32'd1);
        drain_all(id);
    endtask

    initial begin
        int         er;
        logic [3:0] bp;

        user_reset_n     = 1'b0;
        req              = 4'b0000;
        solver_ready     = 1'b1;
        solver_done      = 1'b0;
        solver_out_valid = 1'b0;
        solver_out_data  = 8'h00;
        rsp_ready        = 1'b0;
        cur_words        = words_a;

        // Reset state.
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_start", 32'(solver_start), 32'd0);
        chk("rst_last", 32'(rsp_last), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_solver_reset", 32'(solver_reset), 32'd1);
        user_reset_n = 1'b1;
        tick();
        chk("run_solver_reset", 32'(solver_reset), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single job on requester 0; req dropped after grant must not cancel it.
        req = 4'b0001;
        tick();
        chk("grant_single", 32'(grant), 32'h1);
        chk("start_latency1", 32'(solver_start), 32'd0);
        req = 4'b0000;
        tick();
        chk("start_latency2", 32'(solver_start), 32'd1);
        solver_done      = 1'b1;
        solver_out_valid = 1'b1;
        solver_out_data  = 8'hFF;
        tick();
        solver_done      = 1'b0;
        solver_out_valid = 1'b0;
        capture_rows(8);
        chk("capture_to_rsp", 32'(rsp_valid), 32'd1);
        drain_all(0);

        // Solver busy for 5 cycles after grant (requester 2; pointer is now 1).
        req          = 4'b0100;
        solver_ready = 1'b0;
        tick();
        chk("stall_grant", 32'(grant), 32'h4);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            chk("stall_no_start", 32'(solver_start), 32'd0);
            tick();
        end
        solver_ready = 1'b1;
        tick();
        chk("stall_start", 32'(solver_start), 32'd1);
        tick();
        chk("stall_start_once", 32'(solver_start), 32'd0);
        tick();
        chk("stall_start_once2", 32'(solver_start), 32'd0);
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        cur_words   = words_b;
        capture_rows(8);
        drain_all(2);

        // Backpressure on requester 1 (pointer is now 3, wraps to 1); stray out_valid ignored.
        req = 4'b0010;
        job_to_capture(1);
        req = 4'b0000;
        capture_rows(8);
        bp = 4'b1001;
        er = 0;
        for (int c = 0; c < 40 && er < 8; c++) begin
            rsp_ready        = bp[c % 4];
            solver_out_valid = 1'b1;
            solver_out_data  = 8'h00;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_row", 32'(rsp_row), 32'(er));
            chk("bp_data", 32'(rsp_data), 32'(cur_words[er]));
            chk("bp_last", 32'(rsp_last), 32'(er == 7));
            chk("bp_id", 32'(rsp_id), 32'd1);
            if (rsp_ready) begin
                er++;
            end
            tick();
        end
        solver_out_valid = 1'b0;
        rsp_ready        = 1'b0;
        chk("bp_beats", 32'(er), 32'd8);
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_grant", 32'(grant), 32'd0);

        // Reset during CAPTURE at row 3.
        req = 4'b0001;
        job_to_capture(0);
        req = 4'b0000;
        capture_rows(3);
        user_reset_n = 1'b0;
        tick();
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_solver_reset", 32'(solver_reset), 32'd1);
        user_reset_n = 1'b1;
        tick();
        chk("mid_rst_release", 32'(solver_reset), 32'd0);
        chk("mid_rst_idle", 32'(busy), 32'd0);

        // Round robin with req=1011 held from pointer 0: 0,1,3,0.
        cur_words = words_a;
        req       = 4'b1011;
        full_job(0);
        full_job(1);
        full_job(3);
        full_job(0);
        req = 4'b0000;
        tick();
        chk("rr_end_busy", 32'(busy), 32'd0);
        chk("rr_end_grant", 32'(grant), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/queen_job_scheduler.md
Name: queen_job_scheduler

Overview:
- Shares one 8-queen solver (controller plus datapath) among NUM_REQ requesters.
- Arbitrates round-robin and issues one start pulse per granted job.
- Captures the BOARD row words the solver streams out after done, buffers them, and returns them to the winning requester over a valid/ready stream.
- Sits between the host-side requesters and the solver's start/ready/done/enable_output interface.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- BOARD, 8: board size; rows per result and row-word width.
- TIMEOUT_CYCLES, 65535: watchdog limit, used only with QUEEN_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- user_reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester job request level.
- grant  out  NUM_REQ  one-hot owner of the solver; 0 when idle.
- solver_ready  in  1  solver idle (its ready output).
- solver_start  out  1  one-cycle start pulse to the solver.
- solver_reset  out  1  active-high synchronous reset to the solver (drives its user_reset).
- solver_done  in  1  solver done pulse.
- solver_out_valid  in  1  solver enable_output; one row word per asserted cycle.
- solver_out_data  in  BOARD  one-hot queen column of the current row.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  response beat accepted.
- rsp_data  out  BOARD  buffered row word.
- rsp_row  out  clog2(BOARD)  row index of the beat.
- rsp_last  out  1  final beat of the job.
- rsp_id  out  clog2(NUM_REQ)  index of the granted requester.
- rsp_err  out  1  job aborted; always 0 without QUEEN_TIMEOUT_EN.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (user_reset_n=0, sampled on clk):
  - State goes to IDLE; RR pointer to 0; row counter to 0.
  - grant=0; solver_start=0; rsp_valid=0; rsp_last=0; rsp_err=0; busy=0.
  - solver_reset=1 while user_reset_n=0 (combinational).
  - A reset mid-job drops the job and discards the buffer with no response.
- States: IDLE, START, WAIT_DONE, CAPTURE, DRAIN, ABORT (ABORT exists only with QUEEN_TIMEOUT_EN).
- IDLE:
  - If any req bit is 1, pick the first set bit at or above the RR pointer, wrapping around.
  - Register grant and rsp_id; go to START. Arbitration takes 1 cycle.
- START:
  - solver_start=1 for exactly the cycle in which solver_ready=1, then go to WAIT_DONE.
  - If solver_ready=0, hold START with solver_start=0.
- WAIT_DONE: solver_done=1 -> go to CAPTURE; row counter = 0.
- CAPTURE:
  - Each cycle with solver_out_valid=1 writes solver_out_data to buf[row] and increments row.
  - The BOARD-th write goes to DRAIN with row = 0.
  - out_valid in the same cycle done is seen (in WAIT_DONE) is ignored.
  - out_valid in IDLE, START or DRAIN is ignored.
- DRAIN:
  - rsp_valid=1, rsp_data=buf[row], rsp_row=row, rsp_last=(row==BOARD-1).
  - On rsp_valid and rsp_ready, advance row.
  - Data is held stable while rsp_ready=0.
  - The last beat accepted -> go to IDLE, grant=0, RR pointer = winner+1 mod NUM_REQ.
- Requester rules:
  - grant is stable from the cycle after IDLE until the return to IDLE.
  - Deasserting req after grant does not cancel the job; the response is still delivered.
  - A requester holding req high after its job is re-served only after the other pending requesters (RR fairness).
- Latency:
  - req to solver_start is 2 cycles when solver_ready=1.
  - Capture complete to first rsp_valid is 1 cycle.
- Buffer: BOARD x BOARD flops, written only in CAPTURE, read only in DRAIN.

Optional Feature:
- Macro: QUEEN_TIMEOUT_EN.
- With the macro:
  - A 16-bit cycle counter runs in WAIT_DONE and CAPTURE and clears on entry to START.
  - Reaching TIMEOUT_CYCLES -> go to ABORT.
  - ABORT drives solver_reset=1 for 1 cycle, then emits one beat: rsp_valid=1, rsp_err=1, rsp_last=1, rsp_row=0, rsp_data=0.
  - On acceptance, return to IDLE and advance the RR pointer.
- Without the macro: no counter, no ABORT state, rsp_err tied to 0, and the block waits indefinitely.

Decomposition:
- Shared package holds:
  - the state encoding localparams (4-bit, matching the solver controller's style);
  - BOARD;
  - the clog2-derived widths.
- One sub-module, rr_arbiter: inputs req and pointer, output one-hot grant, purely combinational; registered by the scheduler.

Test Plan:
- Single job: req=4'b0001, solver_ready=1 -> solver_start pulses 2 cycles later; after done plus 8 out_valid words 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08 -> 8 beats with rsp_row 0..7, rsp_id=0, rsp_last only on row 7.
- Round-robin: req=4'b1011 held -> grants issued in order 0,1,3,0; each grant is one-hot and held until its final beat is accepted.
- Backpressure: rsp_ready toggles 1,0,0,1 during DRAIN -> rsp_data/rsp_row stable while stalled; no beat dropped or duplicated.
- solver_ready=0 for 5 cycles after grant -> solver_start stays 0, then pulses exactly once when ready rises.
- Reset mid-job: user_reset_n=0 during CAPTURE at row 3 -> next cycle grant=0, rsp_valid=0, busy=0, solver_reset=1; a following job completes normally.
- With QUEEN_TIMEOUT_EN and TIMEOUT_CYCLES=20, solver_done never asserted -> solver_reset pulses once, then a single beat with rsp_err=1, rsp_last=1; then IDLE.
